// File: rtl/fifo_drain_router_pkg.sv
// Shared constants and FSM encoding for the packet-FIFO drain router.
// The word layout constants match the upstream packet FIFO.
package fifo_drain_router_pkg;

  localparam int WORD_SIZE = 10;
  localparam int DEST_W    = 2;
  localparam int NUM_DEST  = 2 ** DEST_W;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_ROUTE = 3'd3,
    ST_PUSH  = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_drain_router_if.sv
// Bundle of the FIFO read port, downstream channel and status signals of
// the drain router. master = router side, slave = surrounding logic.
interface fifo_drain_router_if
  import fifo_drain_router_pkg::*;
();

  logic                      enable;
  logic                      fifo_empty;
  logic [WORD_SIZE-1:0]      fifo_data_out;
  logic                      fifo_rd;
  logic [NUM_DEST-1:0]       dest_almost_full;
  logic [NUM_DEST-1:0]       out_push;
  logic [WORD_SIZE-1:0]      out_data;
  logic                      busy;
  logic [NUM_DEST*CNT_W-1:0] deliv_cnt;

  modport master (
    input  enable, fifo_empty, fifo_data_out, dest_almost_full,
    output fifo_rd, out_push, out_data, busy, deliv_cnt
  );

  modport slave (
    output enable, fifo_empty, fifo_data_out, dest_almost_full,
    input  fifo_rd, out_push, out_data, busy, deliv_cnt
  );

endinterface

// File: rtl/fifo_drain_router_dest_counter_bank.sv
// Per-destination delivery counters. Each counter advances by one on its
// bit of the one-hot increment vector and wraps silently.
module dest_counter_bank
  import fifo_drain_router_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DEST-1:0]       inc,
  output logic [NUM_DEST*CNT_W-1:0] cnt
);

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_cnt
    logic [CNT_W-1:0] cnt_r;

    // Count deliveries to channel d; overflow wraps to zero.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (inc[d]) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    assign cnt[d*CNT_W +: CNT_W] = cnt_r;
  end

endmodule

// File: rtl/fifo_drain_router.sv
// Read-side consumer of the packet FIFO: pops one word at a time, holds it
// until the target channel has room, then pushes it there and counts it.
// All handshake outputs come straight from flops.
module fifo_drain_router
  import fifo_drain_router_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  fifo_drain_router_if.master bus
);

  state_e                    state_r;
  state_e                    state_s;
  logic                      fifo_rd_r;
  logic [NUM_DEST-1:0]       push_r;
  logic [NUM_DEST-1:0]       push_s;
  logic                      busy_r;
  logic [WORD_SIZE-1:0]      hold_r;
  logic [DEST_W-1:0]         dest_s;
  logic [NUM_DEST*CNT_W-1:0] cnt_s;

  assign dest_s = hold_r[WORD_SIZE-1 -: DEST_W];

  // Next-state decode; the FIFO empty flag only matters when a new word may start.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.enable && !bus.fifo_empty) state_s = ST_READ;
        else                               state_s = ST_IDLE;
      end
      ST_READ:  state_s = ST_CAPT;
      ST_CAPT:  state_s = ST_ROUTE;
      ST_ROUTE: begin
        if (!bus.dest_almost_full[dest_s]) state_s = ST_PUSH;
        else                               state_s = ST_ROUTE;
      end
      ST_PUSH: begin
        if (bus.enable && !bus.fifo_empty) state_s = ST_READ;
        else                               state_s = ST_IDLE;
      end
      default:  state_s = ST_IDLE;
    endcase
  end

  // One-hot push strobe for the coming cycle, aimed at the held word's channel.
  always_comb begin
    push_s = {NUM_DEST{1'b0}};
    if (state_s == ST_PUSH) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        push_s[i] = (dest_s == DEST_W'(i));
      end
    end else begin
      push_s = {NUM_DEST{1'b0}};
    end
  end

  // State register plus Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      fifo_rd_r <= 1'b0;
      push_r    <= {NUM_DEST{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      fifo_rd_r <= (state_s == ST_READ);
      push_r    <= push_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Capture the popped word one cycle after the read; it doubles as out_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r <= {WORD_SIZE{1'b0}};
    end else if (state_r == ST_CAPT) begin
      hold_r <= bus.fifo_data_out;
    end
  end

  dest_counter_bank u_counters (
    .clk   (clk),
    .reset (reset),
    .inc   (push_r),
    .cnt   (cnt_s)
  );

  assign bus.fifo_rd   = fifo_rd_r;
  assign bus.out_push  = push_r;
  assign bus.out_data  = hold_r;
  assign bus.busy      = busy_r;
  assign bus.deliv_cnt = cnt_s;

endmodule

// File: tb/tb_fifo_drain_router.sv
// Bench for fifo_drain_router: upstream FIFO model, word-timeline reference
// model compared every cycle, directed scenarios with literal expectations,
// then a randomized phase.
module tb_fifo_drain_router;
  import fifo_drain_router_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_drain_router_if bus();

  fifo_drain_router dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WORD_SIZE-1:0] up_q[$];
  int                   rd_log[$];
  int                   push_log[$];
  logic [3:0]           pval_log[$];
  logic [9:0]           pdata_log[$];

  // reference model: life of the word currently being handled
  bit         m_active;
  int         m_age;      // cycles since this word's read cycle
  bit         m_pushed;   // this cycle is the word's delivery cycle
  logic [9:0] m_held;
  int         m_cnt[4];
  logic [3:0] exp_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_cnt_vec();
    logic [31:0] v;
    for (int d = 0; d < 4; d++) v[d*8 +: 8] = 8'(m_cnt[d]);
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // upstream FIFO: data appears the cycle after a sampled read
  always @(posedge clk) begin
    if (reset) begin
      bus.fifo_data_out <= 10'h000;
    end else if (bus.fifo_rd) begin
      chk("rd_nonempty", 32'(up_q.size() != 0), 32'd1);
      if (up_q.size() != 0) bus.fifo_data_out <= up_q.pop_front();
    end
  end

  // empty flag follows the queue, settled well before the next rising edge
  always @(negedge clk) begin
    #2;
    bus.fifo_empty = (up_q.size() == 0);
  end

  // reference model: a word starts when free and data waits, is captured
  // two edges after the read, and is delivered one cycle after its
  // channel is seen without almost_full
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_age = 0; m_pushed = 1'b0; m_held = 10'h000;
      for (int d = 0; d < 4; d++) m_cnt[d] = 0;
    end else if (!m_active || m_pushed) begin
      if (m_pushed) m_cnt[m_held[9:8]] = (m_cnt[m_held[9:8]] + 1) % 256;
      m_pushed = 1'b0;
      m_age    = 0;
      m_active = bus.enable && !bus.fifo_empty;
    end else begin
      if (m_age == 1) m_held = bus.fifo_data_out;
      else if (m_age >= 2 && !bus.dest_almost_full[m_held[9:8]]) m_pushed = 1'b1;
      m_age++;
    end
  end

  // per-cycle comparison against the model, plus event logging
  always @(negedge clk) begin
    if (!reset) begin
      exp_push = m_pushed ? (4'b0001 << m_held[9:8]) : 4'b0000;
      chk("fifo_rd",   32'(bus.fifo_rd),   32'(m_active && m_age == 0 && !m_pushed));
      chk("out_push",  32'(bus.out_push),  32'(exp_push));
      chk("busy",      32'(bus.busy),      32'(m_active));
      chk("out_data",  32'(bus.out_data),  32'(m_held));
      chk("deliv_cnt", 32'(bus.deliv_cnt), m_cnt_vec());
      chk("push_onehot0", 32'($onehot0(bus.out_push)), 32'd1);
      if (bus.fifo_rd) rd_log.push_back(cyc);
      if (bus.out_push != 4'b0000) begin
        push_log.push_back(cyc);
        pval_log.push_back(bus.out_push);
        pdata_log.push_back(bus.out_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rd(input string name);
    int k;
    k = 0;
    while (!bus.fifo_rd && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(bus.fifo_rd), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    tick(1);
    while ((bus.busy || (bus.enable && up_q.size() != 0)) && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int rb, pb;
    logic [9:0] w;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.dest_almost_full = 4'b0000;
    tick(3);
    chk("rst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
    chk("rst_out_push",  32'(bus.out_push),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_deliv_cnt", 32'(bus.deliv_cnt), 32'd0);
    reset = 1'b0;
    tick(1);

    // T1: reset while stalled in ROUTE
    bus.enable = 1'b1;
    bus.dest_almost_full = 4'b1111;
    up_q.push_back(10'h0AA);
    wait_rd("t1_rd");
    tick(4);
    chk("t1_busy_before",  32'(bus.busy),     32'd1);
    chk("t1_data_before",  32'(bus.out_data), 32'h0AA);
    #2 reset = 1'b1;
    #1;
    chk("t1_fifo_rd",   32'(bus.fifo_rd),   32'd0);
    chk("t1_out_push",  32'(bus.out_push),  32'd0);
    chk("t1_out_data",  32'(bus.out_data),  32'd0);
    chk("t1_busy",      32'(bus.busy),      32'd0);
    chk("t1_deliv_cnt", 32'(bus.deliv_cnt), 32'd0);
    @(negedge clk);
    bus.dest_almost_full = 4'b0000;
    reset = 1'b0;
    tick(3);
    chk("t1_idle_after", 32'(bus.busy), 32'd0);

    // T2: single word to channel 2
    rb = rd_log.size(); pb = push_log.size();
    up_q.push_back(10'b10_1010_0101);
    wait_idle("t2", 40);
    chk("t2_rd_count",   32'(rd_log.size() - rb),   32'd1);
    chk("t2_push_count", 32'(push_log.size() - pb), 32'd1);
    chk("t2_push_val",   32'(pval_log[pb]),         32'(4'b0100));
    chk("t2_push_data",  32'(pdata_log[pb]),        32'h2A5);
    chk("t2_latency",    32'(push_log[pb] - rd_log[rb]), 32'd3);
    chk("t2_cnt",        32'(bus.deliv_cnt),        32'h0001_0000);

    // T3: stream to channels 0..3
    rb = rd_log.size(); pb = push_log.size();
    for (int d = 0; d < 4; d++) begin
      w = {2'(d), 8'($urandom)};
      up_q.push_back(w);
    end
    wait_idle("t3", 100);
    chk("t3_push_count", 32'(push_log.size() - pb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_push_val", 32'(pval_log[pb+i]), 32'(4'b0001 << i));
      if (i > 0) chk("t3_spacing", 32'(push_log[pb+i] - push_log[pb+i-1]), 32'd4);
    end
    chk("t3_cnt", 32'(bus.deliv_cnt), 32'h0102_0101);

    // T4a: almost_full on other channels is ignored
    bus.dest_almost_full = 4'b1101;
    rb = rd_log.size(); pb = push_log.size();
    up_q.push_back(10'h13C);
    wait_idle("t4a", 40);
    chk("t4a_latency",  32'(push_log[pb] - rd_log[rb]), 32'd3);
    chk("t4a_push_val", 32'(pval_log[pb]),              32'(4'b0010));

    // T4b: stall on the target channel
    bus.dest_almost_full = 4'b0010;
    rb = rd_log.size(); pb = push_log.size();
    up_q.push_back(10'h155);
    wait_rd("t4b_rd");
    tick(2);
    up_q.push_back(10'h0F0);
    tick(6);
    chk("t4b_stall_busy",  32'(bus.busy),                 32'd1);
    chk("t4b_stall_push",  32'(push_log.size() - pb),     32'd0);
    chk("t4b_stall_rd",    32'(rd_log.size() - rb),       32'd1);
    bus.dest_almost_full = 4'b0000;
    tick(1);
    chk("t4b_release_push", 32'(bus.out_push), 32'(4'b0010));
    chk("t4b_release_data", 32'(bus.out_data), 32'h155);
    wait_idle("t4b", 40);
    chk("t4b_push_count", 32'(push_log.size() - pb), 32'd2);
    chk("t4b_second_val", 32'(pval_log[pb+1]),        32'(4'b0001));

    // T5: enable drops during CAPT with three words queued
    rb = rd_log.size(); pb = push_log.size();
    up_q.push_back(10'h211);
    up_q.push_back(10'h022);
    up_q.push_back(10'h133);
    wait_rd("t5_rd");
    tick(1);
    bus.enable = 1'b0;
    wait_idle("t5", 20);
    tick(5);
    chk("t5_push_count", 32'(push_log.size() - pb), 32'd1);
    chk("t5_push_data",  32'(pdata_log[pb]),        32'h211);
    chk("t5_rd_count",   32'(rd_log.size() - rb),   32'd1);
    chk("t5_fifo_left",  32'(up_q.size()),          32'd2);
    bus.enable = 1'b1;
    wait_idle("t5_drain", 40);
    chk("t5_drained",    32'(up_q.size()),          32'd0);
    chk("t5_push_total", 32'(push_log.size() - pb), 32'd3);

    // T6: counter wrap on channel 3
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    chk("t6_cnt_start", 32'(bus.deliv_cnt), 32'd0);
    pb = push_log.size();
    for (int i = 0; i < 256; i++) begin
      w = {2'b11, 8'($urandom)};
      up_q.push_back(w);
    end
    wait_idle("t6", 1400);
    chk("t6_push_count", 32'(push_log.size() - pb), 32'd256);
    chk("t6_cnt_wrap",   32'(bus.deliv_cnt),        32'd0);
    up_q.push_back(10'h3FF);
    wait_idle("t6_one_more", 40);
    chk("t6_cnt_after",  32'(bus.deliv_cnt),        32'h0100_0000);

    // randomized traffic, enable and backpressure
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = 10'($urandom);
        up_q.push_back(w);
      end
      if ($urandom_range(0, 15) == 0) bus.enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.dest_almost_full = 4'($urandom);
      tick(1);
    end
    bus.dest_almost_full = 4'b0000;
    bus.enable = 1'b1;
    wait_idle("rand_drain", 3000);
    chk("rand_fifo_empty", 32'(up_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
